// File: rtl/sigma_delta_fast_demod_if.sv
// Packed sigma-delta link bundle: word offer/accept plus the decimated sample.
// master drives en/sdIn and observes ready/out/outValid/overrun; slave is the demodulator side.
// OUTLEN = packed word width, OUTW = decimated sample width.
interface sigma_delta_fast_demod_if #(
  parameter int OUTLEN = 16,
  parameter int OUTW   = 16
);
  logic              en;        // word strobe, taken when en && ready
  logic [OUTLEN-1:0] sdIn;      // packed bits, bit 0 first
  logic              ready;     // a word can be taken this cycle
  logic [OUTW-1:0]   out;       // decimated unsigned sample
  logic              outValid;  // one-cycle strobe, out updated
  logic              overrun;   // sticky: word offered while not ready

  modport master (output en, sdIn, input  ready, out, outValid, overrun);
  modport slave  (input  en, sdIn, output ready, out, outValid, overrun);
endinterface

// File: rtl/sigma_delta_fast_demod.sv
// Purpose: unpack OUTLEN-bit sigma-delta words LSB first into a sinc3 (CIC) decimator, one sample per OSR bits.
// Latency: bit i of a word accepted at edge t is integrated at edge t+1+i; out/outValid follow the block's last bit by one edge.
// Backpressure: ready while at most one bit is pending; a word offered while not ready is dropped and sets sticky overrun.
// Ports: clk, rst (async, active-low), sd (slave modport: en, sdIn, ready, out, outValid, overrun).
module sigma_delta_fast_demod #(
  parameter  int OUTLEN = 16,
  parameter  int OSR    = 32,
  localparam int OUTW   = 3*$clog2(OSR)+1
) (
  input logic                    clk,
  input logic                    rst,
  sigma_delta_fast_demod_if.slave sd
);

  localparam int REMW = $clog2(OUTLEN+1);
  localparam int CNTW = $clog2(OSR);

  logic [OUTLEN-1:0] sreg;
  logic [REMW-1:0]   rem;
  logic [CNTW-1:0]   cnt;
  logic [OUTW-1:0]   i1, i2, i3;
  logic [OUTW-1:0]   d_z, c1_z, c2_z;
  logic              samp;
  logic [OUTW-1:0]   out_q;
  logic              out_vld_q;
  logic              ovr_q;

  logic              accept;
  logic              proc;
  logic              x;
  logic [OUTW-1:0]   i1_nx, i2_nx, i3_nx;
  logic [OUTW-1:0]   c1, c2, c3;

  // Taking a word while the last old bit is still pending keeps the bit stream gapless.
  assign sd.ready    = (rem <= REMW'(1));
  assign accept      = sd.en && sd.ready;
  assign proc        = (rem != '0);
  assign x           = sreg[0];
  assign sd.out      = out_q;
  assign sd.outValid = out_vld_q;
  assign sd.overrun  = ovr_q;

  // Integrator chain uses the freshly updated lower stage; all arithmetic wraps modulo 2^OUTW.
  always_comb begin
    i1_nx = i1 + {{(OUTW-1){1'b0}}, x};
    i2_nx = i2 + i1_nx;
    i3_nx = i3 + i2_nx;
    c1    = i3 - d_z;
    c2    = c1 - c1_z;
    c3    = c2 - c2_z;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg  <= '0;
      rem   <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (accept) begin
        sreg <= sd.sdIn;
        rem  <= REMW'(OUTLEN);
      end else if (proc) begin
        sreg <= sreg >> 1;
        rem  <= rem - REMW'(1);
      end
      if (sd.en && !sd.ready) begin
        ovr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1   <= '0;
      i2   <= '0;
      i3   <= '0;
      cnt  <= '0;
      samp <= 1'b0;
    end else begin
      // samp marks that i3 now holds the value after the block's last bit.
      samp <= proc && (cnt == CNTW'(OSR-1));
      if (proc) begin
        i1  <= i1_nx;
        i2  <= i2_nx;
        i3  <= i3_nx;
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Comb section runs once per block on the registered decimated integrator value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_z       <= '0;
      c1_z      <= '0;
      c2_z      <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= samp;
      if (samp) begin
        d_z   <= i3;
        c1_z  <= c1;
        c2_z  <= c2;
        out_q <= c3;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_fast_demod.sv
module tb_sigma_delta_fast_demod;
  localparam int OUTLEN = 16;
  localparam int OSR    = 32;
  localparam int OUTW   = 3*$clog2(OSR)+1;
  localparam int HLEN   = 3*OSR-2;

  logic clk;
  logic rst;

  sigma_delta_fast_demod_if #(.OUTLEN(OUTLEN), .OUTW(OUTW)) bus();

  sigma_delta_fast_demod #(.OUTLEN(OUTLEN), .OSR(OSR)) dut (
    .clk (clk),
    .rst (rst),
    .sd  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sinc3 impulse response = count of (a,b,c) in [0,OSR)^3 summing to m.
  int h [HLEN];
  initial begin
    for (int m = 0; m < HLEN; m++) h[m] = 0;
    for (int a = 0; a < OSR; a++)
      for (int b = 0; b < OSR; b++)
        for (int c = 0; c < OSR; c++)
          h[a+b+c]++;
  end

  int hist[$];     // every processed bit since reset, in order
  int pend_bits[$];  // bits accepted but not yet processed

  // Decimated sample after n processed bits: filter output on the zero-initialised bit stream.
  function automatic logic [OUTW-1:0] sinc3_at(input int n);
    int acc;
    logic [31:0] a32;
    acc = 0;
    for (int m = 0; m < HLEN; m++)
      if (n-1-m >= 0) acc += h[m] * hist[n-1-m];
    a32 = acc;
    return a32[OUTW-1:0];
  endfunction

  logic [OUTW-1:0] exp_out = '0;
  logic [OUTW-1:0] pend_out = '0;
  logic exp_valid = 1'b0;
  logic pend_valid = 1'b0;
  logic exp_ovr = 1'b0;
  logic exp_ready = 1'b1;

  always @(posedge clk or negedge rst) begin : model
    logic acc_w;
    if (!rst) begin
      pend_bits.delete();
      hist.delete();
      exp_out = '0; pend_out = '0;
      exp_valid = 1'b0; pend_valid = 1'b0;
      exp_ovr = 1'b0; exp_ready = 1'b1;
    end else begin
      acc_w = bus.en && (pend_bits.size() <= 1);
      if (bus.en && !acc_w) exp_ovr = 1'b1;
      exp_valid = pend_valid;
      if (pend_valid) exp_out = pend_out;
      pend_valid = 1'b0;
      if (pend_bits.size() > 0) begin
        hist.push_back(pend_bits.pop_front());
        if (hist.size() % OSR == 0) begin
          pend_valid = 1'b1;
          pend_out = sinc3_at(hist.size());
        end
      end
      if (acc_w)
        for (int i = 0; i < OUTLEN; i++) pend_bits.push_back(int'(bus.sdIn[i]));
      exp_ready = (pend_bits.size() <= 1);
    end
  end

  bit chk_on = 0;
  logic [OUTW-1:0] got[$];

  always @(negedge clk) begin
    if (bus.outValid === 1'b1) got.push_back(bus.out);
    if (chk_on) begin
      chk("ready", 32'(bus.ready), 32'(exp_ready));
      chk("outValid", 32'(bus.outValid), 32'(exp_valid));
      chk("out", 32'(bus.out), 32'(exp_out));
      chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; bus.en = 1'b0;
    got.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input logic [OUTLEN-1:0] w, input int period);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.sdIn = w;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (period-2) @(posedge clk);
  endtask

  task automatic flush();
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic chk_ffff_seq(input string tag);
    logic [OUTW-1:0] ref_seq [4];
    ref_seq = '{16'd5984, 16'd27808, 16'd32768, 16'd32768};
    chk({tag, "_count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("%s_out%0d", tag, i), 32'(got[i]), 32'(ref_seq[i]));
  endtask

  initial begin : stim
    int lows;
    int u, macc;
    logic [OUTLEN-1:0] w;
    rst = 1'b0; bus.en = 1'b0; bus.sdIn = '0;
    do_reset();
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_outValid", 32'(bus.outValid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk_on = 1;

    // All ones, one word per OUTLEN cycles.
    repeat (8) send(16'hFFFF, 16);
    flush();
    chk_ffff_seq("ones16");
    chk("ones16_ovr", 32'(bus.overrun), 32'd0);

    // All zeros.
    do_reset();
    repeat (8) send(16'h0000, 16);
    flush();
    chk("zeros_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) chk("zeros_out3", 32'(got[3]), 32'd0);

    // Half density.
    do_reset();
    repeat (8) send(16'hAAAA, 16);
    flush();
    chk("aaaa_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("aaaa_out2", 32'(got[2]), 32'd16384);
      chk("aaaa_out3", 32'(got[3]), 32'd16384);
    end

    // en held continuously.
    do_reset();
    @(posedge clk); #1;
    bus.en = 1'b1; bus.sdIn = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 chk("held_ovr_early", 32'(bus.overrun), 32'd1);
    repeat (20) @(posedge clk);
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b0) lows++;
    end
    chk("held_ready_lows", 32'(lows), 32'd15);
    repeat (128 - 38) @(posedge clk);
    #1 bus.en = 1'b0;
    flush();
    if (got.size() >= 4) got = got[0:3];
    chk_ffff_seq("held");

    // Gapped input: one word every 20 cycles.
    do_reset();
    repeat (8) send(16'hFFFF, 20);
    flush();
    chk_ffff_seq("gap20");

    // Reset in the middle of a word.
    do_reset();
    repeat (6) send(16'hFFFF, 16);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.sdIn = 16'hFFFF;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out", 32'(bus.out), 32'd0);
    chk("midrst_outValid", 32'(bus.outValid), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd1);
    got.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) send(16'hFFFF, 16);
    flush();
    chk("midrst_count", 32'(got.size()), 32'd3);
    if (got.size() >= 3) chk("midrst_out2", 32'(got[2]), 32'd32768);

    // Random phase: first-order modulated slowly varying 4-bit level, random offers.
    do_reset();
    u = 0; macc = 0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (cyc % 64 == 0) u = $urandom_range(0, 15);
      for (int b = 0; b < OUTLEN; b++) begin
        macc += u;
        w[b] = (macc >= 16);
        if (macc >= 16) macc -= 16;
      end
      if ($urandom_range(0, 9) == 0) w = OUTLEN'($urandom);
      @(posedge clk); #1;
      bus.en = ($urandom_range(0, 3) == 0);
      bus.sdIn = w;
    end
    @(posedge clk); #1 bus.en = 1'b0;
    flush();
    chk("rand_outputs_seen", 32'(got.size() > 500), 32'd1);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
